// File: rtl/flick_arbiter.sv
// Round-robin owner of a single blink generator: the granted requester receives K lit/dark
// half-periods on flick_out, then a one-cycle done pulse, and the pointer moves past it.
module flick_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned TICK_DIV = 250000,
    parameter int unsigned CNT_W    = 21,
    parameter int unsigned BLINK_W  = 4
) (
    input  logic                     clk_2MHz,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*BLINK_W-1:0] blink_cnt,
    output logic [N_REQ-1:0]         grant,
    output logic                     flick_out,
    output logic [N_REQ-1:0]         done,
    output logic                     busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [BLINK_W-1:0] rem_q, rem_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               flick_q, flick_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;
    logic               tick;
    logic [PTR_W-1:0]   owner_next;

    // First set request at or above the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % int'(N_REQ));
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign tick       = (div_q == CNT_W'(TICK_DIV - 1));
    assign owner_next = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        done_d  = '0;
        flick_d = flick_q;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    busy_d            = 1'b1;
                    div_d             = '0;
                    rem_d             = blink_cnt[int'(pick_idx)*BLINK_W +: BLINK_W];
                    flick_d           = (rem_d != '0);
                    state_d           = StOn;
                end
            end
            StOn, StOff: begin
                // A zero count parks in StOn for its single grant cycle, then finishes.
                if (state_q == StOn && rem_q == '0) begin
                    state_d = StDone;
                end else if (!req[owner_q]) begin
                    state_d = StIdle;
                end else if (tick) begin
                    div_d = '0;
                    if (state_q == StOn) begin
                        state_d = StOff;
                        flick_d = 1'b0;
                    end else begin
                        rem_d = rem_q - BLINK_W'(1);
                        if (rem_q == BLINK_W'(1)) begin
                            state_d = StDone;
                        end else begin
                            state_d = StOn;
                            flick_d = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end

                if (state_d == StDone || state_d == StIdle) begin
                    done_d  = (state_d == StDone) ? grant_q : '0;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    flick_d = 1'b0;
                    div_d   = '0;
                    ptr_d   = owner_next;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_2MHz) begin
        if (reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            flick_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            flick_q <= flick_d;
            busy_q  <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign flick_out = flick_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_flick_arbiter.sv
// Directed bench for flick_arbiter with a short half-period (TICK_DIV=4).
module tb_flick_arbiter;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned BLINK_W  = 4;

    logic                     clk_2MHz = 1'b0;
    logic                     reset    = 1'b1;
    logic [N_REQ-1:0]         req      = '0;
    logic [N_REQ*BLINK_W-1:0] blink_cnt = '0;
    logic [N_REQ-1:0]         grant;
    logic                     flick_out;
    logic [N_REQ-1:0]         done;
    logic                     busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    flick_arbiter #(
        .N_REQ   (N_REQ),
        .TICK_DIV(TICK_DIV),
        .CNT_W   (CNT_W),
        .BLINK_W (BLINK_W)
    ) dut (
        .clk_2MHz (clk_2MHz),
        .reset    (reset),
        .req      (req),
        .blink_cnt(blink_cnt),
        .grant    (grant),
        .flick_out(flick_out),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk_2MHz = ~clk_2MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_2MHz);
        #1;
        cyc++;
    endtask

    // Wait for the next rising grant (bounded) and check its owner.
    task automatic wait_rise(input string tag, input logic [N_REQ-1:0] exp, output int t);
        int n = 0;
        while (grant != '0 && n < 60) begin step(); n++; end
        while (grant == '0 && n < 60) begin step(); n++; end
        check(tag, 32'(grant), 32'(exp));
        t = cyc;
    endtask

    logic [N_REQ-1:0] rr_exp [5];
    int t_now;
    int t_prev;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t_prev = 0;

        // Reset state
        step(); step(); step();
        check("rst_grant", 32'(grant), 0);
        check("rst_flick", 32'(flick_out), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        step();

        // Round robin, every count = 1: service 8 cycles, DONE, IDLE, then next grant
        blink_cnt = 16'h1111;
        req       = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_rise($sformatf("rr_grant_%0d", n), rr_exp[n], t_now);
            check($sformatf("rr_flick_%0d", n), 32'(flick_out), 1);
            if (n > 0) check($sformatf("rr_spacing_%0d", n), 32'(t_now - t_prev), 10);
            t_prev = t_now;
            if (n < 4) begin
                for (int c = 0; c < 8; c++) step();
                check($sformatf("rr_done_%0d", n), 32'(done), 32'(rr_exp[n]));
                check($sformatf("rr_busy_%0d", n), 32'(busy), 0);
            end
        end
        req = 4'b0000;
        step();
        check("rr_abort_grant", 32'(grant), 0);

        // Single requester, two blinks (pointer is 1, search wraps to 0)
        blink_cnt = 16'h0002;
        req       = 4'b0001;
        wait_rise("single_grant", 4'b0001, t_now);
        check("single_flick_0", 32'(flick_out), 1);
        check("single_busy", 32'(busy), 1);
        for (int c = 1; c < 16; c++) begin
            step();
            check($sformatf("single_flick_%0d", c), 32'(flick_out), 32'((c % 8) < 4));
        end
        check("single_nodone_15", 32'(done), 0);
        step();
        check("single_done", 32'(done), 32'(4'b0001));
        check("single_done_busy", 32'(busy), 0);
        check("single_done_grant", 32'(grant), 0);
        check("single_done_flick", 32'(flick_out), 0);
        req = 4'b0000;
        step();
        check("single_done_once", 32'(done), 0);

        // Zero count on requester 2
        blink_cnt = 16'h0000;
        req       = 4'b0100;
        wait_rise("zero_grant", 4'b0100, t_now);
        check("zero_flick_g", 32'(flick_out), 0);
        step();
        check("zero_done", 32'(done), 32'(4'b0100));
        check("zero_grant_off", 32'(grant), 0);
        check("zero_flick_d", 32'(flick_out), 0);
        req = 4'b0000;
        step();

        // Abort of requester 1 at G+5; pointer then sits at 2
        blink_cnt = 16'h0030;
        req       = 4'b0010;
        wait_rise("abort_grant", 4'b0010, t_now);
        for (int c = 0; c < 5; c++) step();
        req = 4'b0000;
        step();
        check("abort_grant_off", 32'(grant), 0);
        check("abort_flick", 32'(flick_out), 0);
        check("abort_no_done", 32'(done), 0);
        check("abort_busy", 32'(busy), 0);
        blink_cnt = 16'h0011;
        req       = 4'b0011;
        wait_rise("abort_next_a", 4'b0001, t_now);
        for (int c = 0; c < 8; c++) step();
        check("abort_next_a_done", 32'(done), 32'(4'b0001));
        req = 4'b0010;
        wait_rise("abort_next_b", 4'b0010, t_now);
        for (int c = 0; c < 8; c++) step();
        check("abort_next_b_done", 32'(done), 32'(4'b0010));
        req = 4'b0000;
        step();

        // Reset two cycles into service; pointer must restart at 0
        blink_cnt = 16'h2000;
        req       = 4'b1000;
        wait_rise("rstmid_grant", 4'b1000, t_now);
        step(); step();
        reset = 1'b1;
        step();
        check("rstmid_grant_off", 32'(grant), 0);
        check("rstmid_flick", 32'(flick_out), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_done", 32'(done), 0);
        reset     = 1'b0;
        blink_cnt = 16'h2020;
        req       = 4'b1010;
        wait_rise("rstmid_ptr", 4'b0010, t_now);
        req = 4'b0000;
        step();

        // Count changed after the grant edge is ignored
        blink_cnt = 16'h0002;
        req       = 4'b0001;
        wait_rise("cntchg_grant", 4'b0001, t_now);
        blink_cnt = 16'h0005;
        for (int c = 0; c < 15; c++) step();
        check("cntchg_nodone", 32'(done), 0);
        step();
        check("cntchg_done", 32'(done), 32'(4'b0001));
        req = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
